// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel input debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_WAIT_LO = 2'd3
  } db_state_t;

  // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/synchronizer.sv
// N-stage flip-flop synchronizer for one asynchronous input bit.
module synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sr_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sr_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_ctrl.sv
// Per-channel synchronizer plus debounce FSM producing clean levels and edge strobes.
module debounce_ctrl
  import debounce_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_evt
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic                reset_n;
  logic [CHANNELS-1:0] sync_s;

  assign reset_n = ~reset;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    synchronizer #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i    (clk),
      .reset_n_i(reset_n),
      .d_i      (raw_in[c]),
      .q_o      (sync_s[c])
    );

    // Strobes default low so they last exactly one cycle.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
        ST_LOW: begin
          if (sync_s[c] && en) begin
            state_d = ST_WAIT_HI;
            cnt_d   = CNT_ONE;
          end
        end
        ST_WAIT_HI: begin
          if (!sync_s[c] || !en) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_HIGH;
            level_d = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!sync_s[c] && en) begin
            state_d = ST_WAIT_LO;
            cnt_d   = CNT_ONE;
          end
        end
        ST_WAIT_LO: begin
          if (sync_s[c] || !en) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_LOW;
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign level[c] = level_q;
    assign rise[c]  = rise_q;
    assign fall[c]  = fall_q;
  end

  assign any_evt = |(rise | fall);

endmodule

// File: tb/tb_debounce_ctrl.sv
// Scoreboard bench for debounce_ctrl: directed scenarios then random stimulus vs. a run-length model.
module tb_debounce_ctrl;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic [CH-1:0] raw_in = '0;
  logic [CH-1:0] level, rise, fall;
  logic          any_evt;

  always #5 clk = ~clk;

  debounce_ctrl #(
    .CHANNELS       (CH),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .raw_in (raw_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .any_evt(any_evt)
  );

  typedef struct packed {
    logic [CH-1:0] lvl;
    logic [CH-1:0] r;
    logic [CH-1:0] f;
    logic          a;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: raw delayed by SS edges, level flips after DC consecutive qualifying edges.
  logic [CH-1:0] m_hist[SS];
  logic [CH-1:0] m_lvl;
  int            m_run[CH];

  function automatic void check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endfunction

  function automatic void model_reset();
    exp_t x;
    for (int i = 0; i < SS; i++) m_hist[i] = '0;
    m_lvl = '0;
    for (int c = 0; c < CH; c++) m_run[c] = 0;
    x = '0;
    exp_q.push_back(x);
  endfunction

  function automatic void model_step(input logic [CH-1:0] r, input logic e);
    exp_t          x;
    logic [CH-1:0] s;
    s = m_hist[SS-1];
    for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = r;
    x = '0;
    for (int c = 0; c < CH; c++) begin
      if (e && (s[c] != m_lvl[c])) m_run[c]++;
      else m_run[c] = 0;
      if (m_run[c] == DC) begin
        m_lvl[c] = s[c];
        m_run[c] = 0;
        if (s[c]) x.r[c] = 1'b1;
        else x.f[c] = 1'b1;
      end
    end
    x.lvl = m_lvl;
    x.a   = |(x.r | x.f);
    exp_q.push_back(x);
  endfunction

  task automatic cyc(input logic [CH-1:0] r, input logic e, input logic rs);
    logic was;
    @(negedge clk);
    was    = reset;
    reset  = rs;
    raw_in = r;
    en     = e;
    if (rs) begin
      if (!was) begin
        #1;
        check("reset_level", level, '0);
        check("reset_rise", rise, '0);
        check("reset_fall", fall, '0);
        check("reset_any", {{(CH-1){1'b0}}, any_evt}, '0);
      end
      model_reset();
    end else begin
      model_step(r, e);
    end
  endtask

  task automatic hold(input logic [CH-1:0] r, input logic e, input int n);
    for (int i = 0; i < n; i++) cyc(r, e, 1'b0);
  endtask

  // Monitor: one expected entry per clock edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("level", level, x.lvl);
        check("rise", rise, x.r);
        check("fall", fall, x.f);
        check("any_evt", {{(CH-1){1'b0}}, any_evt}, {{(CH-1){1'b0}}, x.a});
        check("rise_fall_excl", rise & fall, '0);
      end
    end
  end

  initial begin
    logic [CH-1:0] cur;
    logic          e;
    logic [6:0]    pat;
    for (int i = 0; i < SS; i++) m_hist[i] = '0;
    m_lvl = '0;
    for (int c = 0; c < CH; c++) m_run[c] = 0;

    for (int i = 0; i < 3; i++) cyc('0, 1'b1, 1'b1);
    hold('0, 1'b1, 2);

    // Single channel rise after full latency.
    hold(4'b0001, 1'b1, 10);

    // Bouncy channel 1: 1,1,0,1,1,1,1 then held.
    pat = 7'b1111011;
    for (int i = 0; i < 7; i++) cyc({2'b00, pat[i], 1'b1}, 1'b1, 1'b0);
    hold(4'b0011, 1'b1, 8);

    // Channel 2 high then low.
    hold(4'b0111, 1'b1, 10);
    hold(4'b0011, 1'b1, 10);

    // All channels together, both directions.
    hold(4'b0000, 1'b1, 10);
    hold(4'b1111, 1'b1, 10);
    hold(4'b0000, 1'b1, 10);

    // Enable dropped mid-wait on channel 3.
    hold(4'b1000, 1'b1, 4);
    hold(4'b1000, 1'b0, 4);
    hold(4'b1000, 1'b1, 12);
    hold(4'b0000, 1'b1, 10);

    // Reset one cycle before an expected rise.
    hold(4'b0001, 1'b1, 4);
    cyc(4'b0001, 1'b1, 1'b1);
    cyc(4'b0001, 1'b1, 1'b1);
    hold(4'b0001, 1'b1, 10);

    // Randomized phase.
    cur = '0;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
      e = ($urandom_range(0, 19) != 0);
      cyc(cur, e, ($urandom_range(0, 249) == 0));
    end

    hold(cur, 1'b1, 3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
